test_xor: RTL and testbench
===========================

Name: test_xor

Overview:
- Self-contained single-cycle MIPS32 subset processor with a built-in instruction ROM.
- The ROM holds a fixed XOR self-test program.
- Exposes the PC, the current opcode, the write-back data, registers $t0–$t3 and error flags for a system-level bench.
- Used as the top of the XOR instruction test in the MIPS32 SoC flow.

Parameters:
- RESET_PC, 32'h0040_0000, byte address loaded into the PC on reset; also the ROM base address.
- ROM_WORDS, 16, number of 32-bit ROM words. Unused words hold 32'h0000_0000 (nop).

Ports:
- CLK  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- invpc  out  1  high when the current PC is invalid.
- iAddr  out  32  current PC (byte address).
- t_0  out  32  register $8 ($t0).
- t_1  out  32  register $9 ($t1).
- t_2  out  32  register $10 ($t2).
- t_3  out  32  register $11 ($t3).
- error  out  11  error flag vector.
- iOp  out  6  opcode field [31:26] of the current instruction.
- w_0  out  32  register-file write-back data for the current instruction.

Behaviour:
- Reset: on a CLK rising edge with reset==0:
  - PC <= RESET_PC.
  - All 32 registers <= 0.
  - Resulting outputs: t_0..t_3=0, iAddr=RESET_PC.
- Execution: on each rising edge with reset==1, one instruction completes. Register write and PC update occur at that edge, so latency is 1 cycle.
- All outputs are combinational from PC, ROM and register state.
- Register $0 always reads 0; writes to it are discarded.
- Supported instructions:
  - R-type (op 0): add, sub, and, or, xor, nor, slt; funct 0x20, 0x22, 0x24, 0x25, 0x26, 0x27, 0x2A.
  - I-type: addi (0x08), andi (0x0C), ori (0x0D), xori (0x0E), lui (0x0F).
  - Jump: j (0x02).
  - sll with all fields 0 (nop).
- Arithmetic:
  - 32-bit two's complement, wrap-around; no overflow traps.
  - addi sign-extends its immediate; andi/ori/xori zero-extend.
  - lui writes imm<<16.
  - slt is a signed compare.
- PC update:
  - Normally PC+4.
  - j: PC <= {PC+4[31:28], target, 2'b00}.
  - The PC does not advance while invpc=1 (core halts until reset).
- invpc = 1 when PC[1:0]!=0, or PC < RESET_PC, or PC >= RESET_PC+4*ROM_WORDS.
- error bits:
  - [0] unknown opcode.
  - [1] unknown funct when op=0.
  - [2] = invpc.
  - [3] R-type with shamt!=0 other than the nop.
  - [10:4] = 0.
- An erroneous instruction writes no register; PC behaves as for a nop, except that the invpc halt still applies.
- w_0 = ALU result of the current instruction; 0 when the instruction does not write.
- ROM program (word index: instruction), starting at RESET_PC:
  - 0: ori $t0,$0,0xAABB
  - 1: ori $t1,$0,0xA0B0
  - 2: xor $t0,$t0,$t1
  - 3: xor $t0,$t0,$t1
  - 4: j (self), infinite halt loop
  - 5.. : nop
- Required register trace after each post-reset edge:
  - Edge 1: t_0=0000AABB.
  - Edge 2: t_1=0000A0B0.
  - Edge 3: t_0=00000A0B.
  - Edge 4: t_0=0000AABB.
  - Edge 5 and later: t_0 and t_1 unchanged; t_2=t_3=0.
- Reset asserted mid-program: the next edge restores PC and clears registers; the program restarts from word 0.

Optional Feature:
- STICKY_ERROR_EN defined: error[3:0] bits latch at each rising edge where they are set, ORed with the live value. They clear only on reset.
- Undefined: error is purely combinational from the current instruction and PC.

Test Plan:
- Hold reset=0 for one edge, then release it → iAddr=00400000, t_0..t_3=0, iOp=0x0D, invpc=0, error=0.
- One edge after release → t_0=0000AABB, w_0 reflects the next instruction (0000A0B0).
- Second edge → t_1=0000A0B0, t_0 still 0000AABB.
- Third edge → t_0=00000A0B; fourth edge → t_0=0000AABB.
- Fifth and sixth edges → iAddr stays 00400010, t_0=0000AABB, t_1=0000A0B0, t_2=t_3=0.
- Assert reset=0 after edge 3, apply one edge → t_0=0, iAddr=00400000; release → trace repeats from edge 1.

Source files
------------

// File: rtl/test_xor.sv
// Single-cycle MIPS32 subset core with a built-in XOR self-test ROM.
// Optional: define STICKY_ERROR_EN to latch error[3:0] until reset.
module test_xor #(
   parameter logic [31:0] RESET_PC  = 32'h0040_0000,
   parameter int          ROM_WORDS = 16
) (
   input  logic        CLK,
   input  logic        reset,
   output logic        invpc,
   output logic [31:0] iAddr,
   output logic [31:0] t_0,
   output logic [31:0] t_1,
   output logic [31:0] t_2,
   output logic [31:0] t_3,
   output logic [10:0] error,
   output logic [5:0]  iOp,
   output logic [31:0] w_0
);

   localparam logic [31:0] ROM_END = RESET_PC + 32'(4 * ROM_WORDS);

   logic [31:0] pc_q, pc_d;
   logic [31:0] regs_q [32];
   logic [31:0] regs_d [32];

   logic [31:0] instr, off, pc_plus4;
   logic [31:0] a, b, res;
   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, shamt, dst;
   logic [15:0] imm;
   logic        wr, wen, jump, bad;
   logic        err_op, err_fn, err_sh;
   logic [10:0] err_live;

   // ROM contents, addressed by byte offset from the ROM base
   function automatic logic [31:0] rom_fetch(input logic [31:0] o);
      case (o)
         32'h00:  rom_fetch = 32'h3408_AABB;
         32'h04:  rom_fetch = 32'h3409_A0B0;
         32'h08:  rom_fetch = 32'h0109_4026;
         32'h0C:  rom_fetch = 32'h0109_4026;
         32'h10:  rom_fetch = 32'h0810_0004;
         default: rom_fetch = 32'h0000_0000;
      endcase
   endfunction

   // fetch, field split and operand read
   always_comb begin
      invpc = (pc_q[1:0] != 2'b00) || (pc_q < RESET_PC)
              || (pc_q >= ROM_END);
      off   = pc_q - RESET_PC;
      instr = invpc ? 32'h0 : rom_fetch(off);
      op    = instr[31:26];
      rs    = instr[25:21];
      rt    = instr[20:16];
      rd    = instr[15:11];
      shamt = instr[10:6];
      funct = instr[5:0];
      imm   = instr[15:0];
      a     = (rs == 5'd0) ? 32'h0 : regs_q[rs];
      b     = (rt == 5'd0) ? 32'h0 : regs_q[rt];
      pc_plus4 = pc_q + 32'd4;
   end

   // decode and ALU
   always_comb begin
      res    = 32'h0;
      wr     = 1'b0;
      dst    = 5'd0;
      jump   = 1'b0;
      err_op = 1'b0;
      err_fn = 1'b0;
      err_sh = 1'b0;
      case (op)
         6'h00: begin
            dst    = rd;
            wr     = 1'b1;
            err_sh = (shamt != 5'd0);
            case (funct)
               6'h20: res = a + b;
               6'h22: res = a - b;
               6'h24: res = a & b;
               6'h25: res = a | b;
               6'h26: res = a ^ b;
               6'h27: res = ~(a | b);
               6'h2A: res = {31'b0, $signed(a) < $signed(b)};
               6'h00: begin
                  wr     = 1'b0;
                  err_fn = (instr != 32'h0);
               end
               default: begin
                  wr     = 1'b0;
                  err_fn = 1'b1;
               end
            endcase
         end
         6'h08: begin
            dst = rt;
            wr  = 1'b1;
            res = a + {{16{imm[15]}}, imm};
         end
         6'h0C: begin
            dst = rt;
            wr  = 1'b1;
            res = a & {16'h0, imm};
         end
         6'h0D: begin
            dst = rt;
            wr  = 1'b1;
            res = a | {16'h0, imm};
         end
         6'h0E: begin
            dst = rt;
            wr  = 1'b1;
            res = a ^ {16'h0, imm};
         end
         6'h0F: begin
            dst = rt;
            wr  = 1'b1;
            res = {imm, 16'h0};
         end
         6'h02:   jump = 1'b1;
         default: err_op = 1'b1;
      endcase
   end

   // write-back, next PC and error vector
   always_comb begin
      err_live = {7'b0, err_sh, invpc, err_fn, err_op};
      bad      = |err_live;
      wen      = wr && !bad && (dst != 5'd0);
      w_0      = wen ? res : 32'h0;
      regs_d   = regs_q;
      if (wen) regs_d[dst] = res;
      if (invpc)
         pc_d = pc_q;
      else if (jump && !bad)
         pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
      else
         pc_d = pc_plus4;
   end

   // PC and register file state
   always_ff @(posedge CLK) begin
      if (!reset) begin
         pc_q <= RESET_PC;
         for (int i = 0; i < 32; i++) regs_q[i] <= 32'h0;
      end else begin
         pc_q   <= pc_d;
         regs_q <= regs_d;
      end
   end

`ifdef STICKY_ERROR_EN
   logic [3:0] stk_q, stk_d;

   // accumulate error flags until the next reset
   always_comb begin
      stk_d = stk_q | err_live[3:0];
      error = {7'b0, err_live[3:0] | stk_q};
   end

   // sticky error register
   always_ff @(posedge CLK) begin
      if (!reset) stk_q <= 4'h0;
      else        stk_q <= stk_d;
   end
`else
   // error flags follow the current instruction and PC
   always_comb error = err_live;
`endif

   // visible state
   always_comb begin
      iAddr = pc_q;
      iOp   = op;
      t_0   = regs_q[8];
      t_1   = regs_q[9];
      t_2   = regs_q[10];
      t_3   = regs_q[11];
   end

endmodule

// File: tb/tb_test_xor.sv
// Self-checking bench for test_xor: directed trace plus random resets
// compared against a program-level model of the XOR self-test.
module tb_test_xor;

   logic        CLK = 1'b0;
   logic        reset = 1'b0;
   logic        invpc;
   logic [31:0] iAddr, t_0, t_1, t_2, t_3, w_0;
   logic [10:0] error;
   logic [5:0]  iOp;

   int checks = 0;
   int failures = 0;

   logic [31:0] m_pc;
   logic [31:0] m_r8, m_r9;

   test_xor dut (
      .CLK(CLK), .reset(reset), .invpc(invpc), .iAddr(iAddr),
      .t_0(t_0), .t_1(t_1), .t_2(t_2), .t_3(t_3),
      .error(error), .iOp(iOp), .w_0(w_0)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int m_idx();
      return int'((m_pc - 32'h0040_0000) >> 2);
   endfunction

   function automatic logic [31:0] m_wb();
      case (m_idx())
         0: return 32'h0000_AABB;
         1: return 32'h0000_A0B0;
         2, 3: return m_r8 ^ m_r9;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [5:0] m_op();
      case (m_idx())
         0, 1: return 6'h0D;
         4: return 6'h02;
         default: return 6'h00;
      endcase
   endfunction

   task automatic m_step(input logic rst);
      if (!rst) begin
         m_pc = 32'h0040_0000;
         m_r8 = 0;
         m_r9 = 0;
      end else begin
         case (m_idx())
            0: m_r8 = 32'h0000_AABB;
            1: m_r9 = 32'h0000_A0B0;
            2, 3: m_r8 = m_r8 ^ m_r9;
            default: ;
         endcase
         if (m_idx() != 4) m_pc = m_pc + 4;
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".iAddr"}, iAddr, m_pc);
      check({tag, ".t_0"}, t_0, m_r8);
      check({tag, ".t_1"}, t_1, m_r9);
      check({tag, ".t_2"}, t_2, 32'h0);
      check({tag, ".t_3"}, t_3, 32'h0);
      check({tag, ".iOp"}, {26'h0, iOp}, {26'h0, m_op()});
      check({tag, ".w_0"}, w_0, m_wb());
      check({tag, ".invpc"}, {31'h0, invpc}, 32'h0);
      check({tag, ".error"}, {21'h0, error}, 32'h0);
   endtask

   task automatic step(input logic rst, input string tag);
      reset = rst;
      @(posedge CLK);
      m_step(rst);
      #1;
      check_all(tag);
   endtask

   initial begin
      step(1'b0, "rst");
      check("rst_pc", iAddr, 32'h0040_0000);
      check("rst_op", {26'h0, iOp}, 32'h0D);
      step(1'b1, "e1");
      check("e1_t0", t_0, 32'h0000_AABB);
      check("e1_w0", w_0, 32'h0000_A0B0);
      step(1'b1, "e2");
      check("e2_t1", t_1, 32'h0000_A0B0);
      step(1'b1, "e3");
      check("e3_t0", t_0, 32'h0000_0A0B);
      step(1'b0, "mid_rst");
      check("mid_t0", t_0, 32'h0);
      check("mid_pc", iAddr, 32'h0040_0000);
      step(1'b1, "r1");
      check("r1_t0", t_0, 32'h0000_AABB);
      step(1'b1, "r2");
      step(1'b1, "r3");
      step(1'b1, "r4");
      check("r4_t0", t_0, 32'h0000_AABB);
      step(1'b1, "r5");
      check("r5_pc", iAddr, 32'h0040_0010);
      step(1'b1, "r6");
      check("r6_pc", iAddr, 32'h0040_0010);
      check("r6_t1", t_1, 32'h0000_A0B0);
      for (int i = 0; i < 80; i++) begin
         step(($urandom_range(0, 9) != 0), "rnd");
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
